palette_ctrl: RTL and testbench
===============================

Name: palette_ctrl

Overview:
- Programmable 16-entry RGB palette controller that sits between the sprite/background index source and the VGA DAC outputs.
- Game logic writes colours into a shadow palette over a valid/ready port and requests a commit.
- The controller copies shadow to active only at the start of vertical blanking, so palette effects (flash, swap) never tear mid-frame.
- Runs a registered 1-cycle lookup of the 4-bit pixel index into the active palette.

Parameters:
- NUM_ENTRIES, 16, palette depth; index width is $clog2(NUM_ENTRIES) = 4.
- CH_W, 8, bits per colour channel.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  synchronous active-low reset
- vblank  in  1  level, high during vertical blanking (from VGA controller)
- wr_valid  in  1  shadow write request
- wr_ready  out  1  shadow write accepted when wr_valid & wr_ready
- wr_idx  in  4  shadow entry index
- wr_rgb  in  24  {R,G,B} for the entry
- commit_req  in  1  single-cycle pulse: copy shadow to active at next vblank rise
- commit_pending  out  1  high from accepted commit_req until copy finishes
- commit_done  out  1  1-cycle pulse after the last entry is copied
- pix_valid  in  1  pixel index valid
- sprite_data  in  4  pixel palette index
- rgb_valid  out  1  pix_valid delayed 1 cycle
- VGA_R, VGA_G, VGA_B  out  8 each  registered colour

Behaviour:
- Reset (Reset_n low at a Clk edge):
  - Shadow and active palettes load DEFAULT_PALETTE: 0 = 40E0D0, 1 = 161616, 2 = F8F8F8, 3 = DDC06B, 4 = 00CFDF, 5 = 00699F, 6 = 0160C5, 7 = A61814, 8 = 2BD9CC, 9 = 949494, 10 = 84F8B8, 11–15 = 40E0D0.
  - FSM goes to IDLE. Outputs: wr_ready = 1, commit_pending = 0, commit_done = 0, rgb_valid = 0, VGA_R/G/B = 0.
  - Reset during COPY aborts the copy, and active is restored to defaults.
- vblank edge detect: vb_q is vblank registered; vb_rise = vblank & ~vb_q. vb_q resets to 1 so no spurious rise after reset.
- FSM states:
  - IDLE: commit_req -> ARMED.
  - ARMED: vb_rise -> COPY, cnt = 0.
  - COPY: active[cnt] <= shadow[cnt]; cnt++. When cnt == 15 -> DONE.
  - DONE: one cycle, commit_done = 1, then -> IDLE, or -> ARMED if a re-arm flag is set.
- wr_ready = 0 only in COPY; it is 1 in all other states. An accepted write updates shadow on the same edge.
- Writes in ARMED are legal and land in the commit.
- commit_pending = 1 in ARMED, COPY, DONE; it clears the cycle after DONE unless re-armed.
- commit_req in ARMED is a no-op.
- commit_req in COPY or DONE sets rearm. rearm causes DONE -> ARMED, and clears on entering ARMED.
- vb_rise while in IDLE or COPY is ignored.
- Commit latency: copy starts the cycle after vb_rise; 16 copy cycles plus the DONE cycle.
- Lookup: each cycle, {VGA_R,VGA_G,VGA_B} <= active[sprite_data] and rgb_valid <= pix_valid; latency 1.
  - The lookup continues during COPY. An entry read in the same cycle it is copied returns the old value.
  - When pix_valid = 0, colour outputs hold their last value.

Optional Feature:
- Macro PALETTE_FADE_EN.
- When defined:
  - Extra input fade_lvl [1:0] is sampled with each lookup.
  - Each output channel is the active channel >> fade_lvl (0 = full, 3 = 1/8). The shift is applied in the same registered stage, so latency stays 1.
- When undefined:
  - The port is absent and the output is the unshifted palette value.

Decomposition:
- Package palette_pkg holds:
  - rgb_t, a packed struct with r, g, b of 8 bits each.
  - pal_idx_t, logic [3:0].
  - The state enum: IDLE, ARMED, COPY, DONE.
  - DEFAULT_PALETTE, a constant rgb_t [16].
- One natural sub-module, palette_regfile: two 16 x 24 register banks with one write port (shadow), a copy path (shadow to active per index), one async read of active, and reset-to-default.
- The FSM and lookup register stay in palette_ctrl.

Test Plan:
- Reset then lookup: sprite_data = 7, pix_valid = 1 -> next cycle rgb_valid = 1 and VGA = A6/18/14; sprite_data = 12 -> 40/E0/D0.
- Write idx 1 = FF0000 with no commit -> lookup of idx 1 stays 16/16/16 across a full vblank.
- Same write plus commit_req, then vblank 0->1 -> commit_pending high until commit_done; commit_done occurs 17 cycles after vb_rise; then idx 1 reads FF/00/00.
- Issue commit_req mid-COPY -> after DONE the FSM is in ARMED with commit_pending still 1; a wr_valid held through COPY sees wr_ready = 0 and is accepted the first cycle after COPY.
- Assert Reset_n = 0 at copy cycle 5 -> all outputs zero, and after release idx 2 reads F8/F8/F8 (default) with no commit_done pulse.
- PALETTE_FADE_EN defined, fade_lvl = 2, idx 2 -> VGA = 3E/3E/3E.

Source files
------------

// File: rtl/palette_pkg.sv
// Shared types and constants for the palette controller.
package palette_pkg;

  localparam int unsigned NUM_ENTRIES = 16;
  localparam int unsigned IDX_W       = $clog2(NUM_ENTRIES);
  localparam int unsigned CH_W        = 8;
  localparam int unsigned RGB_W       = 3 * CH_W;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  typedef logic [IDX_W-1:0] pal_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COPY  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam pal_idx_t LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  // Listed from entry 15 down to entry 0 (packed array, MSB first).
  localparam rgb_t [NUM_ENTRIES-1:0] DEFAULT_PALETTE = {
    24'h40E0D0, 24'h40E0D0, 24'h40E0D0, 24'h40E0D0, // 15..12
    24'h40E0D0, 24'h84F8B8, 24'h949494, 24'h2BD9CC, // 11..8
    24'hA61814, 24'h0160C5, 24'h00699F, 24'h00CFDF, // 7..4
    24'hDDC06B, 24'hF8F8F8, 24'h161616, 24'h40E0D0  // 3..0
  };

endpackage

// File: rtl/palette_regfile.sv
// Shadow and active palette banks: one shadow write port, per-index
// shadow->active copy path, async read of active, reset to defaults.
module palette_regfile
  import palette_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     wr_en,
  input  pal_idx_t wr_idx,
  input  rgb_t     wr_data,
  input  logic     cp_en,
  input  pal_idx_t cp_idx,
  input  pal_idx_t rd_idx,
  output rgb_t     rd_data_c
);

  rgb_t [NUM_ENTRIES-1:0] shadow_q, shadow_d;
  rgb_t [NUM_ENTRIES-1:0] active_q, active_d;

  // Next bank contents: shadow takes host writes, active takes one copied entry.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en) shadow_d[wr_idx] = wr_data;
    if (cp_en) active_d[cp_idx] = shadow_q[cp_idx];
  end

  // Bank registers, both restored to the default palette on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= DEFAULT_PALETTE;
      active_q <= DEFAULT_PALETTE;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign rd_data_c = active_q[rd_idx];

endmodule

// File: rtl/palette_ctrl.sv
// Palette controller: shadow writes, vblank-synchronised commit to the active
// palette, and a registered 1-cycle index->RGB lookup.
// Optional: define PALETTE_FADE_EN to add fade_lvl (per-channel right shift).
module palette_ctrl
  import palette_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              vblank,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [RGB_W-1:0]  wr_rgb,
  input  logic              commit_req,
  output logic              commit_pending,
  output logic              commit_done,
  input  logic              pix_valid,
  input  logic [IDX_W-1:0]  sprite_data,
`ifdef PALETTE_FADE_EN
  input  logic [1:0]        fade_lvl,
`endif
  output logic              rgb_valid,
  output logic [CH_W-1:0]   VGA_R,
  output logic [CH_W-1:0]   VGA_G,
  output logic [CH_W-1:0]   VGA_B
);

  state_e   state_q, state_d;
  pal_idx_t cnt_q, cnt_d;
  logic     rearm_q, rearm_d;
  logic     vb_q, vb_d;
  logic     vb_rise;
  logic     wr_ready_q, wr_ready_d;
  logic     commit_pending_q, commit_pending_d;
  logic     commit_done_q, commit_done_d;
  logic     rgb_valid_q, rgb_valid_d;
  rgb_t     rgb_q, rgb_d;
  rgb_t     pal_rd_c;
  rgb_t     lut_c;
  logic     wr_en;
  logic     cp_en;

  palette_regfile u_regfile (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .wr_en     (wr_en),
    .wr_idx    (pal_idx_t'(wr_idx)),
    .wr_data   (rgb_t'(wr_rgb)),
    .cp_en     (cp_en),
    .cp_idx    (cnt_q),
    .rd_idx    (pal_idx_t'(sprite_data)),
    .rd_data_c (pal_rd_c)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; the commit waits in ARMED for the vblank rising edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_req) state_d = ARMED;
      ARMED:   if (vb_rise) state_d = COPY;
      COPY:    if (cnt_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = (rearm_q || commit_req) ? ARMED : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the status outputs come straight off flops.
  always_comb begin
    wr_ready_d       = (state_d != COPY);
    commit_pending_d = (state_d != IDLE);
    commit_done_d    = (state_d == DONE);
  end

  // Copy counter, re-arm flag, vblank edge detect and shadow/copy strobes.
  always_comb begin
    vb_d    = vblank;
    vb_rise = vblank & ~vb_q;
    wr_en   = wr_valid & wr_ready_q;
    cp_en   = (state_q == COPY);
    cnt_d   = cnt_q;
    if (state_q == ARMED && vb_rise) cnt_d = '0;
    else if (state_q == COPY)        cnt_d = cnt_q + IDX_W'(1);
    rearm_d = rearm_q;
    if (commit_req && (state_q == COPY || state_q == DONE)) rearm_d = 1'b1;
    if (state_d == ARMED) rearm_d = 1'b0;
  end

  // Lookup stage: palette read (optionally faded); colour holds when no pixel.
  always_comb begin
    lut_c = pal_rd_c;
`ifdef PALETTE_FADE_EN
    lut_c.r = pal_rd_c.r >> fade_lvl;
    lut_c.g = pal_rd_c.g >> fade_lvl;
    lut_c.b = pal_rd_c.b >> fade_lvl;
`endif
    rgb_valid_d = pix_valid;
    rgb_d       = pix_valid ? lut_c : rgb_q;
  end

  // Control and output registers; vb_q resets high to avoid a false rise.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q            <= '0;
      rearm_q          <= 1'b0;
      vb_q             <= 1'b1;
      wr_ready_q       <= 1'b1;
      commit_pending_q <= 1'b0;
      commit_done_q    <= 1'b0;
      rgb_valid_q      <= 1'b0;
      rgb_q            <= '0;
    end else begin
      cnt_q            <= cnt_d;
      rearm_q          <= rearm_d;
      vb_q             <= vb_d;
      wr_ready_q       <= wr_ready_d;
      commit_pending_q <= commit_pending_d;
      commit_done_q    <= commit_done_d;
      rgb_valid_q      <= rgb_valid_d;
      rgb_q            <= rgb_d;
    end
  end

  assign wr_ready       = wr_ready_q;
  assign commit_pending = commit_pending_q;
  assign commit_done    = commit_done_q;
  assign rgb_valid      = rgb_valid_q;
  assign VGA_R          = rgb_q.r;
  assign VGA_G          = rgb_q.g;
  assign VGA_B          = rgb_q.b;

endmodule

// File: tb/tb_palette_ctrl.sv
// Testbench for palette_ctrl: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a behavioural palette model.
module tb_palette_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        vblank;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_idx;
  logic [23:0] wr_rgb;
  logic        commit_req;
  logic        commit_pending;
  logic        commit_done;
  logic        pix_valid;
  logic [3:0]  sprite_data;
  logic [1:0]  fade_v;
  logic        rgb_valid;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  palette_ctrl dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .vblank         (vblank),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_idx         (wr_idx),
    .wr_rgb         (wr_rgb),
    .commit_req     (commit_req),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .pix_valid      (pix_valid),
    .sprite_data    (sprite_data),
`ifdef PALETTE_FADE_EN
    .fade_lvl       (fade_v),
`endif
    .rgb_valid      (rgb_valid),
    .VGA_R          (VGA_R),
    .VGA_G          (VGA_G),
    .VGA_B          (VGA_B)
  );

  logic [23:0] def_pal [16] = '{
    24'h40E0D0, 24'h161616, 24'hF8F8F8, 24'hDDC06B,
    24'h00CFDF, 24'h00699F, 24'h0160C5, 24'hA61814,
    24'h2BD9CC, 24'h949494, 24'h84F8B8, 24'h40E0D0,
    24'h40E0D0, 24'h40E0D0, 24'h40E0D0, 24'h40E0D0
  };

  // Reference model: palettes plus commit progress (-1 none, 0..15 copying, 16 done).
  logic [23:0] m_shadow [16];
  logic [23:0] m_active [16];
  bit          m_vb_prev, m_armed, m_rearm;
  int          m_pos;
  logic        e_ready, e_pend, e_done, e_rv;
  logic [23:0] e_rgb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [23:0] fade(input logic [23:0] c, input logic [1:0] f);
    logic [7:0] r, g, b;
    r = c[23:16] >> f;
    g = c[15:8] >> f;
    b = c[7:0] >> f;
    return {r, g, b};
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit rise, copying;
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) begin
        m_shadow[i] = def_pal[i];
        m_active[i] = def_pal[i];
      end
      m_vb_prev = 1'b1; m_armed = 1'b0; m_rearm = 1'b0; m_pos = -1;
      e_ready = 1'b1; e_pend = 1'b0; e_done = 1'b0; e_rv = 1'b0; e_rgb = '0;
    end else begin
      rise    = vblank && !m_vb_prev;
      copying = (m_pos >= 0) && (m_pos < 16);
      e_rv    = pix_valid;
      if (pix_valid) e_rgb = fade(m_active[sprite_data], fade_v);
      if (wr_valid && !copying) m_shadow[wr_idx] = wr_rgb;
      if (copying) begin
        m_active[m_pos] = m_shadow[m_pos];
        if (commit_req) m_rearm = 1'b1;
        m_pos++;
      end else if (m_pos == 16) begin
        m_armed = m_rearm || commit_req;
        m_rearm = 1'b0;
        m_pos   = -1;
      end else if (m_armed) begin
        if (rise) begin m_armed = 1'b0; m_pos = 0; end
      end else if (commit_req) begin
        m_armed = 1'b1;
      end
      m_vb_prev = vblank;
      e_pend  = m_armed || (m_pos >= 0);
      e_done  = (m_pos == 16);
      e_ready = !((m_pos >= 0) && (m_pos < 16));
    end
  endtask

  // One clock: update model, let the edge pass, compare every output.
  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    chk("wr_ready", wr_ready, e_ready);
    chk("commit_pending", commit_pending, e_pend);
    chk("commit_done", commit_done, e_done);
    chk("rgb_valid", rgb_valid, e_rv);
    chk("vga_rgb", {VGA_R, VGA_G, VGA_B}, e_rgb);
  endtask

  initial begin
    int n, n_done, vb_cnt;
    Reset_n = 1'b0; vblank = 1'b0; wr_valid = 1'b0; wr_idx = '0; wr_rgb = '0;
    commit_req = 1'b0; pix_valid = 1'b0; sprite_data = '0; fade_v = '0;
    tick(); tick();
    chk("rst_vga", {VGA_R, VGA_G, VGA_B}, 24'h0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_pend", commit_pending, 0);
    Reset_n = 1'b1;

    // Default lookups
    pix_valid = 1'b1; sprite_data = 4'd7; tick();
    chk("lut7", {VGA_R, VGA_G, VGA_B}, 24'hA61814);
    chk("lut7_valid", rgb_valid, 1);
    sprite_data = 4'd12; tick();
    chk("lut12", {VGA_R, VGA_G, VGA_B}, 24'h40E0D0);
`ifdef PALETTE_FADE_EN
    fade_v = 2'd2; sprite_data = 4'd2; tick();
    chk("fade2", {VGA_R, VGA_G, VGA_B}, 24'h3E3E3E);
    fade_v = 2'd0;
`endif

    // Shadow write without commit never reaches active
    wr_valid = 1'b1; wr_idx = 4'd1; wr_rgb = 24'hFF0000; tick(); wr_valid = 1'b0;
    vblank = 1'b1; repeat (20) tick(); vblank = 1'b0; tick();
    sprite_data = 4'd1; tick();
    chk("nocommit_idx1", {VGA_R, VGA_G, VGA_B}, 24'h161616);

    // Commit: done pulse 17 cycles after the vblank rise
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    chk("pend_armed", commit_pending, 1);
    vblank = 1'b1; tick(); n = 1;
    while (!commit_done && n < 40) begin tick(); n++; end
    chk("done_latency", n, 17);
    tick();
    chk("commit_idx1", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);
    chk("pend_clear", commit_pending, 0);

    // Re-arm during COPY and a write stalled through COPY
    vblank = 1'b0; commit_req = 1'b1; tick(); commit_req = 1'b0;
    vblank = 1'b1; tick();
    repeat (3) tick();
    commit_req = 1'b1; wr_valid = 1'b1; wr_idx = 4'd3; wr_rgb = 24'h123456; tick();
    commit_req = 1'b0;
    chk("wr_busy", wr_ready, 0);
    n = 0;
    while (!commit_done && n < 40) begin tick(); n++; end
    chk("seen_done", commit_done, 1);
    chk("ready_in_done", wr_ready, 1);
    tick(); wr_valid = 1'b0;
    chk("rearm_pend", commit_pending, 1);

    // Reset in the middle of a copy
    vblank = 1'b0; tick(); vblank = 1'b1; tick();
    repeat (5) tick();
    Reset_n = 1'b0; tick();
    chk("rst_copy_vga", {VGA_R, VGA_G, VGA_B}, 24'h0);
    chk("rst_copy_pend", commit_pending, 0);
    chk("rst_copy_valid", rgb_valid, 0);
    Reset_n = 1'b1; sprite_data = 4'd2; pix_valid = 1'b1; tick();
    chk("rst_copy_idx2", {VGA_R, VGA_G, VGA_B}, 24'hF8F8F8);
    n_done = 0;
    repeat (20) begin tick(); if (commit_done) n_done++; end
    chk("rst_copy_nodone", n_done, 0);

    // Randomized traffic
    vb_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      Reset_n = ($urandom_range(0, 999) != 0);
      if (vb_cnt == 0) begin vblank = ~vblank; vb_cnt = $urandom_range(3, 40); end
      else vb_cnt--;
      commit_req  = ($urandom_range(0, 15) == 0);
      wr_valid    = ($urandom_range(0, 2) == 0);
      wr_idx      = 4'($urandom);
      wr_rgb      = 24'($urandom);
      pix_valid   = ($urandom_range(0, 3) != 0);
      sprite_data = 4'($urandom);
`ifdef PALETTE_FADE_EN
      fade_v      = 2'($urandom);
`endif
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
